seg7_reader: RTL

SEG7_READER -- requirements
Module: seg7_reader

---
 rtl/seg7_reader_if.sv | 31 +++
 rtl/seg7_reader.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/seg7_reader_if.sv
// Bundles the multiplexed 7-segment sample lines with the frame output handshake.
// The DUT connects through the slave modport; the driver/consumer side uses master.
interface seg7_reader_if;
   logic [0:6]  display;
   logic [3:0]  digit_sel;
   logic        frame_ready;
   logic        frame_valid;
   logic [15:0] frame_digits;
   logic [3:0]  frame_err;
   logic        overrun;

   modport master (
      output display,
      output digit_sel,
      output frame_ready,
      input  frame_valid,
      input  frame_digits,
      input  frame_err,
      input  overrun
   );

   modport slave (
      input  display,
      input  digit_sel,
      input  frame_ready,
      output frame_valid,
      output frame_digits,
      output frame_err,
      output overrun
   );
endinterface

// File: rtl/seg7_reader.sv
// Reads a multiplexed 4-digit 7-segment display: debounces each digit dwell,
// decodes the pattern, and hands complete 4-digit frames to a consumer.
module seg7_reader #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic          clk,
   input  logic          reset,
   seg7_reader_if.slave  bus
);

   localparam int unsigned CNT_W = 8;
   localparam int unsigned POS_N = 4;
   localparam int unsigned CODE_W = 4;

   localparam logic [0:0] SCAN = 1'b0;
   localparam logic [0:0] PUSH = 1'b1;

   // The new pair is compared with the registered one, so the count reaches
   // STABLE_CYCLES-1 on the edge where STABLE_CYCLES identical samples were seen.
   localparam logic [CNT_W-1:0] CAP_AT = CNT_W'(STABLE_CYCLES - 2);
   localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(STABLE_CYCLES);

   logic [0:6]                disp_q;
   logic [POS_N-1:0]          sel_q;
   logic [CNT_W-1:0]          cnt_q;

   logic [POS_N*CODE_W-1:0]   shadow_digits_q;
   logic [POS_N-1:0]          shadow_err_q;
   logic [POS_N-1:0]          seen_q;
   logic [POS_N-1:0]          seen_d;

   logic [0:0]                state_q;
   logic [0:0]                state_d;

   logic                      frame_valid_q;
   logic [POS_N*CODE_W-1:0]   frame_digits_q;
   logic [POS_N-1:0]          frame_err_q;
   logic                      overrun_q;
   logic                      overrun_d;
   logic                      load_c;

   logic                      sel_onehot_c;
   logic                      pair_same_c;
   logic                      capture_c;
   logic [POS_N-1:0]          cap_mask_c;
   logic [CODE_W-1:0]         code_c;
   logic                      err_c;

   // Stability qualification of the incoming {display, digit_sel} pair
   always_comb begin
      sel_onehot_c = $onehot(bus.digit_sel);
      pair_same_c  = (bus.display == disp_q) && (bus.digit_sel == sel_q);
      capture_c    = sel_onehot_c && pair_same_c && (cnt_q == CAP_AT);
      cap_mask_c   = capture_c ? bus.digit_sel : '0;
   end

   // Active-low segment decode; anything unlisted is flagged as an error code
   always_comb begin
      code_c = 4'hE;
      err_c  = 1'b1;
      case (bus.display)
         7'b0000001: begin code_c = 4'h0; err_c = 1'b0; end
         7'b1001111: begin code_c = 4'h1; err_c = 1'b0; end
         7'b0010010: begin code_c = 4'h2; err_c = 1'b0; end
         7'b0000110: begin code_c = 4'h3; err_c = 1'b0; end
         7'b1001100: begin code_c = 4'h4; err_c = 1'b0; end
         7'b0100100: begin code_c = 4'h5; err_c = 1'b0; end
         7'b0100000: begin code_c = 4'h6; err_c = 1'b0; end
         7'b0001111: begin code_c = 4'h7; err_c = 1'b0; end
         7'b0000000: begin code_c = 4'h8; err_c = 1'b0; end
         7'b0000100: begin code_c = 4'h9; err_c = 1'b0; end
         7'b1111111: begin code_c = 4'hF; err_c = 1'b0; end
         default:    begin code_c = 4'hE; err_c = 1'b1; end
      endcase
   end

   // Sample register and saturating stability counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         disp_q <= 7'b1111111;
         sel_q  <= '0;
         cnt_q  <= '0;
      end else begin
         disp_q <= bus.display;
         sel_q  <= bus.digit_sel;
         if (!sel_onehot_c || !pair_same_c) begin
            cnt_q <= '0;
         end else if (cnt_q != CNT_SAT) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   // Shadow frame: latest capture per position wins until the frame is pushed
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow_digits_q <= '0;
         shadow_err_q    <= '0;
      end else if (capture_c) begin
         for (int i = 0; i < POS_N; i++) begin
            if (bus.digit_sel[i]) begin
               shadow_digits_q[i*CODE_W +: CODE_W] <= code_c;
               shadow_err_q[i]                     <= err_c;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= SCAN;
         seen_q  <= '0;
      end else begin
         state_q <= state_d;
         seen_q  <= seen_d;
      end
   end

   // Next state; a capture landing in PUSH seeds the following frame
   always_comb begin
      state_d   = state_q;
      seen_d    = seen_q | cap_mask_c;
      load_c    = 1'b0;
      overrun_d = 1'b0;
      case (state_q)
         SCAN: begin
            if (seen_d == '1) begin
               state_d = PUSH;
            end
         end
         PUSH: begin
            state_d = SCAN;
            seen_d  = cap_mask_c;
            if (!frame_valid_q || bus.frame_ready) begin
               load_c = 1'b1;
            end else begin
               overrun_d = 1'b1;
            end
         end
         default: begin
            state_d = SCAN;
            seen_d  = '0;
         end
      endcase
   end

   // Output slot; a fresh load takes priority over the consumer draining it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_valid_q  <= 1'b0;
         frame_digits_q <= '0;
         frame_err_q    <= '0;
         overrun_q      <= 1'b0;
      end else begin
         overrun_q <= overrun_d;
         if (load_c) begin
            frame_valid_q  <= 1'b1;
            frame_digits_q <= shadow_digits_q;
            frame_err_q    <= shadow_err_q;
         end else if (frame_valid_q && bus.frame_ready) begin
            frame_valid_q <= 1'b0;
         end
      end
   end

   assign bus.frame_valid  = frame_valid_q;
   assign bus.frame_digits = frame_digits_q;
   assign bus.frame_err    = frame_err_q;
   assign bus.overrun      = overrun_q;

endmodule
